pipe_hazard_ctrl: RTL and testbench

- Central stall/flush sequencer for the 5-stage pipeline.
- Watches decode operands, the instruction in execute (load, taken branch, halt) and the memory busy flags. Drives the PC write enable and the per-stage write/bubble controls.
- Generates the 3-cycle flush / flush_again / flush_final sequence consumed by the fetch/decode pipeline register.
- Keeps a saturating stall-cycle counter for performance debug.

---
 rtl/pipe_hazard_ctrl_pkg.sv | 15 +
 rtl/pipe_hazard_ctrl_sat_counter.sv | 21 ++
 rtl/pipe_hazard_ctrl.sv | 124 ++++++++++++
 tb/tb_pipe_hazard_ctrl.sv | 305 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pipe_hazard_ctrl_pkg.sv
// Shared types and defaults for the pipeline stall/flush sequencer.
package pipe_hazard_ctrl_pkg;

  localparam int REG_W_DEF = 3;
  localparam int CNT_W_DEF = 16;

  // Sequencer states: normal run, the two trailing flush steps, and halted.
  typedef enum logic [1:0] {
    RUN  = 2'd0,
    FL2  = 2'd1,
    FL3  = 2'd2,
    HALT = 2'd3
  } state_t;

endpackage

// File: rtl/pipe_hazard_ctrl_sat_counter.sv
// Saturating up-counter with synchronous active-high clear.
module sat_counter #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             inc,
  output logic [WIDTH-1:0] q
);

  // Count up on inc, sticking at all-ones instead of wrapping.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    if (rst) begin
      q <= '0;
    end else if (inc && (q != '1)) begin
      q <= q + WIDTH'(1);
    end
  end

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Central stall/flush sequencer for the 5-stage pipeline: load-use stalls,
// redirect flush sequence, memory freezes, halt, and a stall-cycle counter.
module pipe_hazard_ctrl
  import pipe_hazard_ctrl_pkg::*;
#(
  parameter int REG_W = REG_W_DEF,
  parameter int CNT_W = CNT_W_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             fd_valid,
  input  logic [REG_W-1:0] fd_rs,
  input  logic             fd_rs_used,
  input  logic [REG_W-1:0] fd_rt,
  input  logic             fd_rt_used,
  input  logic             de_valid,
  input  logic [REG_W-1:0] de_rd,
  input  logic             de_mem_rd,
  input  logic             de_br_taken,
  input  logic             de_halt,
  input  logic             imem_stall,
  input  logic             dmem_stall,
  output logic             pc_we,
  output logic             fd_we,
  output logic             fd_valid_o,
  output logic             de_bubble,
  output logic             xm_we,
  output logic             mw_we,
  output logic             flush,
  output logic             flush_again,
  output logic             flush_final,
  output logic             halted,
  output logic [CNT_W-1:0] stall_cnt
);

  state_t state, state_nxt;
  logic   redirect;
  logic   loaduse;
  logic   halt_entry;
  logic   stall_inc;

  // A redirect only takes effect when the pipeline is not frozen by data memory.
  assign redirect   = de_valid && de_br_taken && !dmem_stall;
  assign loaduse    = de_valid && de_mem_rd && fd_valid &&
                      ((fd_rs_used && (fd_rs == de_rd)) ||
                       (fd_rt_used && (fd_rt == de_rd)));
  assign halt_entry = de_valid && de_halt && !de_br_taken && !dmem_stall;

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= RUN;
    end else begin
      state <= state_nxt;
    end
  end

  // Next state and pipeline controls, in priority order.
  always_comb begin
    // NOTE: every output gets a default first so no path leaves a latch behind.
    state_nxt   = state;
    pc_we       = 1'b0;
    fd_we       = 1'b0;
    fd_valid_o  = 1'b0;
    de_bubble   = 1'b0;
    xm_we       = 1'b0;
    mw_we       = 1'b0;
    flush       = 1'b0;
    flush_again = 1'b0;
    flush_final = 1'b0;

    if (rst) begin
      state_nxt = RUN;
    end else if (state == HALT) begin
      // Stop fetching, feed bubbles, let older instructions drain.
      fd_we     = 1'b1;
      de_bubble = 1'b1;
      xm_we     = 1'b1;
      mw_we     = 1'b1;
    end else begin
      flush_again = (state == FL2);
      flush_final = (state == FL3);
      if (!dmem_stall) begin
        xm_we = 1'b1;
        mw_we = 1'b1;
        unique case (state)
          FL2:     state_nxt = FL3;
          default: state_nxt = RUN;
        endcase
        if (redirect) begin
          flush     = 1'b1;
          pc_we     = 1'b1;
          fd_we     = 1'b1;
          de_bubble = 1'b1;
          state_nxt = FL2;
        end else if (loaduse) begin
          de_bubble = 1'b1;
        end else if (imem_stall) begin
          fd_we = 1'b1;
        end else begin
          pc_we      = 1'b1;
          fd_we      = 1'b1;
          fd_valid_o = 1'b1;
        end
        if (halt_entry) begin
          state_nxt = HALT;
        end
      end
    end
  end

  assign halted    = (state == HALT);
  assign stall_inc = !rst && (state != HALT) && !pc_we;

  sat_counter #(
    .WIDTH(CNT_W)
  ) u_stall_cnt (
    .clk(clk),
    .rst(rst),
    .inc(stall_inc),
    .q  (stall_cnt)
  );

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Self-checking bench: a queue-based reference model checked every cycle,
// plus directed scenarios with hand-computed expectations.
module tb_pipe_hazard_ctrl;

  localparam int REG_W = 3;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic fd_valid, fd_rs_used, fd_rt_used, de_valid, de_mem_rd;
  logic de_br_taken, de_halt, imem_stall, dmem_stall;
  logic [REG_W-1:0] fd_rs, fd_rt, de_rd;

  logic pc_we, fd_we, fd_valid_o, de_bubble, xm_we, mw_we;
  logic flush, flush_again, flush_final, halted;
  logic [15:0] stall_cnt;

  logic pc_we_n, fd_we_n, fd_valid_o_n, de_bubble_n, xm_we_n, mw_we_n;
  logic flush_n, flush_again_n, flush_final_n, halted_n;
  logic [3:0] stall_cnt_n;

  int checks = 0;
  int errors = 0;
  bit chk_en = 1'b0;

  always #5 clk = ~clk;

  pipe_hazard_ctrl dut (
    .clk(clk), .rst(rst), .fd_valid(fd_valid), .fd_rs(fd_rs), .fd_rs_used(fd_rs_used),
    .fd_rt(fd_rt), .fd_rt_used(fd_rt_used), .de_valid(de_valid), .de_rd(de_rd),
    .de_mem_rd(de_mem_rd), .de_br_taken(de_br_taken), .de_halt(de_halt),
    .imem_stall(imem_stall), .dmem_stall(dmem_stall), .pc_we(pc_we), .fd_we(fd_we),
    .fd_valid_o(fd_valid_o), .de_bubble(de_bubble), .xm_we(xm_we), .mw_we(mw_we),
    .flush(flush), .flush_again(flush_again), .flush_final(flush_final),
    .halted(halted), .stall_cnt(stall_cnt)
  );

  pipe_hazard_ctrl #(.CNT_W(4)) dut_n (
    .clk(clk), .rst(rst), .fd_valid(fd_valid), .fd_rs(fd_rs), .fd_rs_used(fd_rs_used),
    .fd_rt(fd_rt), .fd_rt_used(fd_rt_used), .de_valid(de_valid), .de_rd(de_rd),
    .de_mem_rd(de_mem_rd), .de_br_taken(de_br_taken), .de_halt(de_halt),
    .imem_stall(imem_stall), .dmem_stall(dmem_stall), .pc_we(pc_we_n), .fd_we(fd_we_n),
    .fd_valid_o(fd_valid_o_n), .de_bubble(de_bubble_n), .xm_we(xm_we_n), .mw_we(mw_we_n),
    .flush(flush_n), .flush_again(flush_again_n), .flush_final(flush_final_n),
    .halted(halted_n), .stall_cnt(stall_cnt_n)
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  // After a redirect, the next two advancing cycles carry flush_again then
  // flush_final; those pending steps live in a queue (2 = again, 3 = final).
  int     pend[$];
  bit     m_halted = 1'b0;
  longint m_stalls = 0;

  typedef struct packed {
    logic pc_we, fd_we, fd_valid_o, de_bubble, xm_we, mw_we;
    logic flush, flush_again, flush_final, halted;
  } exp_t;

  exp_t e_cmp, e_upd;

  function automatic logic m_redirect();
    return de_valid && de_br_taken && !dmem_stall;
  endfunction

  function automatic exp_t model_out();
    exp_t e;
    logic lu;
    e = '0;
    lu = de_valid && de_mem_rd && fd_valid &&
         ((fd_rs_used && fd_rs == de_rd) || (fd_rt_used && fd_rt == de_rd));
    e.halted = m_halted;
    if (rst) return e;
    if (m_halted) begin
      e.fd_we = 1; e.de_bubble = 1; e.xm_we = 1; e.mw_we = 1;
      return e;
    end
    if (pend.size() > 0) begin
      e.flush_again = (pend[0] == 2);
      e.flush_final = (pend[0] == 3);
    end
    if (dmem_stall) return e;
    e.xm_we = 1; e.mw_we = 1;
    if (m_redirect()) begin
      e.flush = 1; e.pc_we = 1; e.fd_we = 1; e.de_bubble = 1;
    end else if (lu) begin
      e.de_bubble = 1;
    end else if (imem_stall) begin
      e.fd_we = 1;
    end else begin
      e.pc_we = 1; e.fd_we = 1; e.fd_valid_o = 1;
    end
    return e;
  endfunction

  always @(posedge clk) begin
    e_upd = model_out();
    if (rst) begin
      pend.delete();
      m_halted = 1'b0;
      m_stalls = 0;
    end else if (!m_halted) begin
      if (!e_upd.pc_we) m_stalls++;
      if (!dmem_stall) begin
        if (de_valid && de_halt && !de_br_taken) begin
          m_halted = 1'b1;
          pend.delete();
        end else if (m_redirect()) begin
          pend = {2, 3};
        end else if (pend.size() > 0) begin
          void'(pend.pop_front());
        end
      end
    end
  end

  // Compare DUT outputs with the model every cycle, away from the active edge.
  always @(negedge clk) begin
    if (chk_en) begin
      e_cmp = model_out();
      check("pc_we", pc_we, e_cmp.pc_we);
      check("fd_we", fd_we, e_cmp.fd_we);
      if (fd_we) check("fd_valid_o", fd_valid_o, e_cmp.fd_valid_o);
      check("de_bubble", de_bubble, e_cmp.de_bubble);
      check("xm_we", xm_we, e_cmp.xm_we);
      check("mw_we", mw_we, e_cmp.mw_we);
      check("flush", flush, e_cmp.flush);
      check("flush_again", flush_again, e_cmp.flush_again);
      check("flush_final", flush_final, e_cmp.flush_final);
      check("halted", halted, e_cmp.halted);
      check("stall_cnt", stall_cnt, (m_stalls > 65535) ? 65535 : m_stalls);
      check("pc_we_n", pc_we_n, e_cmp.pc_we);
      check("halted_n", halted_n, e_cmp.halted);
      check("stall_cnt_n", stall_cnt_n, (m_stalls > 15) ? 15 : m_stalls);
    end
  end

  // ---------------- stimulus ----------------
  task automatic mid();
    @(negedge clk);
    #1;
  endtask

  task automatic nxt();
    @(posedge clk);
    #1;
  endtask

  task automatic clr();
    fd_valid = 0; fd_rs = 0; fd_rs_used = 0; fd_rt = 0; fd_rt_used = 0;
    de_valid = 0; de_rd = 0; de_mem_rd = 0; de_br_taken = 0; de_halt = 0;
    imem_stall = 0; dmem_stall = 0;
  endtask

  initial begin
    clr();
    rst = 1;
    nxt();
    chk_en = 1;
    mid();
    check("rst_pc_we", pc_we, 0);
    check("rst_flush", flush, 0);
    nxt();
    rst = 0;

    // Idle after reset.
    mid();
    check("idle_pc_we", pc_we, 1);
    check("idle_fd_we", fd_we, 1);
    check("idle_flushes", {flush, flush_again, flush_final}, 0);
    check("idle_cnt", stall_cnt, 0);
    nxt();

    // Load-use: one stall cycle.
    de_valid = 1; de_mem_rd = 1; de_rd = 3; fd_valid = 1; fd_rs = 3; fd_rs_used = 1;
    mid();
    check("lu_pc_we", pc_we, 0);
    check("lu_bubble", de_bubble, 1);
    nxt();
    de_mem_rd = 0;
    mid();
    check("lu_clear_pc_we", pc_we, 1);
    check("lu_cnt", stall_cnt, 1);
    nxt();

    // Single redirect: flush, flush_again, flush_final, then quiet.
    de_br_taken = 1;
    mid();
    check("br_flush", flush, 1);
    check("br_fd_valid_o", fd_valid_o, 0);
    nxt();
    de_br_taken = 0;
    mid();
    check("br_again", {flush, flush_again}, 2'b01);
    nxt();
    mid();
    check("br_final", flush_final, 1);
    nxt();
    mid();
    check("br_done", {flush, flush_again, flush_final}, 0);
    nxt();

    // Back-to-back redirect restarts the sequence.
    de_br_taken = 1;
    mid();
    nxt();
    mid();
    check("br2_restart", {flush, flush_again}, 2'b11);
    nxt();
    de_br_taken = 0;
    mid();
    check("br2_again", {flush_again, flush_final}, 2'b10);
    nxt();
    mid();
    check("br2_final", flush_final, 1);
    nxt();
    mid();
    nxt();

    // Redirect wins over load-use.
    de_mem_rd = 1; de_br_taken = 1;
    mid();
    check("brlu_flush", flush, 1);
    check("brlu_pc_we", pc_we, 1);
    check("brlu_fd_valid_o", fd_valid_o, 0);
    nxt();
    de_mem_rd = 0; de_br_taken = 0;
    mid();
    check("brlu_cnt", stall_cnt, 1);
    nxt();
    mid();
    nxt();

    // Data-memory freeze while in the flush_again step.
    de_br_taken = 1;
    mid();
    nxt();
    de_br_taken = 0; dmem_stall = 1;
    repeat (4) begin
      mid();
      check("dm_we", {pc_we, fd_we, xm_we, mw_we}, 0);
      check("dm_again", {flush, flush_again}, 2'b01);
      nxt();
    end
    dmem_stall = 0;
    mid();
    check("dm_cnt", stall_cnt, 5);
    check("dm_hold_fl2", flush_again, 1);
    nxt();
    mid();
    check("dm_fl3", flush_final, 1);
    nxt();

    // Instruction-memory stall, long enough to saturate the narrow counter.
    imem_stall = 1;
    mid();
    check("im_pc_we", pc_we, 0);
    check("im_fd_we", fd_we, 1);
    check("im_fd_valid_o", fd_valid_o, 0);
    nxt();
    repeat (19) nxt();
    imem_stall = 0;
    mid();
    check("im_cnt", stall_cnt, 25);
    check("im_cnt_sat", stall_cnt_n, 4'hF);
    nxt();

    // Halt: entry cycle advances normally, then stays halted until reset.
    de_halt = 1;
    mid();
    check("halt_entry_halted", halted, 0);
    check("halt_entry_pc_we", pc_we, 1);
    nxt();
    de_halt = 0; de_br_taken = 1;
    repeat (5) begin
      mid();
      check("halt_halted", halted, 1);
      check("halt_pc_we", pc_we, 0);
      check("halt_flush", flush, 0);
      check("halt_cnt", stall_cnt, 25);
      nxt();
    end
    de_br_taken = 0;
    rst = 1;
    nxt();
    rst = 0;
    mid();
    check("post_rst_halted", halted, 0);
    check("post_rst_pc_we", pc_we, 1);
    check("post_rst_cnt", stall_cnt, 0);
    nxt();
    nxt();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
